// File: rtl/osm_if.sv
// Request/grant and flit bus between the input buffers (master) and one output-port arbiter (slave).
interface osm_if #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned W     = 35
);
    localparam int unsigned SW = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [NPORT-1:0]   req;
    logic [NPORT*W-1:0] din;
    logic [NPORT-1:0]   dvld;
    logic [NPORT-1:0]   ack;
    logic [SW-1:0]      sel;
    logic [W-1:0]       dout;
    logic               dout_vld;
    logic               busy;

    modport master (
        output req, din, dvld,
        input  ack, sel, dout, dout_vld, busy
    );

    modport slave (
        input  req, din, dvld,
        output ack, sel, dout, dout_vld, busy
    );
endinterface

// File: rtl/osm.sv
// Output-side arbiter: round-robin grant of one input at a time, with a registered
// forwarding stage and release on tail flit, request withdrawal or first-flit timeout.
module osm #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned W     = 35,
    parameter int unsigned FLOWH = W - 1,
    parameter int unsigned FLOWL = W - 2,
    parameter logic [1:0]  TAIL  = 2'b11,
    parameter int unsigned TMO   = 15
) (
    input  logic  clk,
    input  logic  rst,
    osm_if.slave  bus
);
    localparam int unsigned SW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, REL} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [NPORT-1:0] ack_q, ack_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             busy_q, busy_d;

    logic [W-1:0]     din_a [NPORT];
    logic [W-1:0]     din_g;
    logic             dv_g, req_g, tail_g, fwd_c;
    logic             gnt_found;
    logic [SW-1:0]    gnt_idx;
    int unsigned      idx;

    // Split the flattened flit bus and pick out the granted input's signals.
    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            din_a[i] = bus.din[i*W +: W];
        end
        din_g  = din_a[sel_q];
        dv_g   = bus.dvld[sel_q];
        req_g  = bus.req[sel_q];
        tail_g = (2'(din_g[FLOWH:FLOWL]) == TAIL);
    end

    // Round-robin search starting at ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!gnt_found && bus.req[SW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wcnt_q     <= '0;
            sel_q      <= '0;
            ack_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wcnt_q     <= wcnt_d;
            sel_q      <= sel_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (gnt_found) state_d = GRANT;
            GRANT: begin
                if (dv_g)                           state_d = tail_g ? REL : BUSY;
                else if (!req_g)                    state_d = REL;
                else if (wcnt_q == CW'(TMO - 1))    state_d = REL;
            end
            BUSY:  if ((dv_g && tail_g) || !req_g) state_d = REL;
            REL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        wcnt_d = wcnt_q;
        sel_d  = sel_q;
        ack_d  = ack_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    sel_d  = gnt_idx;
                    ack_d  = NPORT'(1) << gnt_idx;
                    wcnt_d = '0;
                end
            end
            GRANT: begin
                if (state_d == REL)        ack_d  = '0;
                else if (state_d == GRANT) wcnt_d = wcnt_q + CW'(1);
            end
            BUSY: if (state_d == REL) ack_d = '0;
            REL: begin
                ack_d = '0;
                ptr_d = (sel_q == SW'(NPORT - 1)) ? '0 : sel_q + SW'(1);
            end
            default: ack_d = '0;
        endcase
        busy_d     = (state_d == GRANT) || (state_d == BUSY);
        // Only the granted input's flits reach the link.
        fwd_c      = dv_g && ((state_q == GRANT) || (state_q == BUSY));
        dout_vld_d = fwd_c;
        dout_d     = fwd_c ? din_g : dout_q;
    end

    assign bus.ack      = ack_q;
    assign bus.sel      = sel_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.busy     = busy_q;
endmodule
